// File: rtl/instruction_type_i_mc_pkg.sv
// Shared definitions for the RV32 I-type multi-cycle executor:
// opcodes, funct3 codes, shift-type selectors and the FSM encoding.
package riscv_i_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_ALUI = 7'h13;
  localparam logic [6:0] OPC_LOAD = 7'h03;
  localparam logic [6:0] OPC_JALR = 7'h67;

  // ALU-immediate funct3 codes
  localparam logic [2:0] F3_ADDI  = 3'd0;
  localparam logic [2:0] F3_SLLI  = 3'd1;
  localparam logic [2:0] F3_SLTI  = 3'd2;
  localparam logic [2:0] F3_SLTIU = 3'd3;
  localparam logic [2:0] F3_XORI  = 3'd4;
  localparam logic [2:0] F3_SRXI  = 3'd5;
  localparam logic [2:0] F3_ORI   = 3'd6;
  localparam logic [2:0] F3_ANDI  = 3'd7;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // JALR only defines funct3 = 0
  localparam logic [2:0] F3_JALR = 3'd0;

  // imm[11:5] selects logical vs arithmetic right shift
  localparam logic [6:0] F7_SRLI = 7'h00;
  localparam logic [6:0] F7_SRAI = 7'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    LOAD = 2'd2,
    WB   = 2'd3
  } state_e;

  // True for the five defined load widths
  function automatic logic isLoadF3(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/instruction_type_i_mc_if.sv
// Bus bundle between decode/regfile/RAM (master side) and the executor
// (slave side).
// Handshake: an instruction transfers on a rising edge where iVALID and
// oREADY are both high; the master must hold iIR/iPC/iREG_OUT1 stable while
// iVALID is high, and oREADY never depends on iVALID. The RAM side holds
// oRAM_CE/oRAM_RD/oRAM_ADDR stable until iRAM_ACK is seen on a rising edge.
interface instruction_type_i_mc_if
  import riscv_i_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            iVALID;
  logic            oREADY;
  logic [31:0]     iIR;
  logic [XLEN-1:0] iPC;
  logic [4:0]      oRS1;
  logic [XLEN-1:0] iREG_OUT1;
  logic [4:0]      oRD;
  logic [XLEN-1:0] oREG_IN;
  logic            oREG_WE;
  logic            oRAM_CE;
  logic            oRAM_RD;
  logic            oRAM_WR;
  logic [XLEN-1:0] oRAM_ADDR;
  logic [31:0]     iRAM_DATA;
  logic            iRAM_ACK;
  logic [XLEN-1:0] oPCBR;
  logic            oPCBR_VALID;
  logic            oMISALIGN;
  logic            oILLEGAL;
  logic            oERR;
  state_e          dbgState;

  modport slave (
    input  iVALID, iIR, iPC, iREG_OUT1, iRAM_DATA, iRAM_ACK,
    output oREADY, oRS1, oRD, oREG_IN, oREG_WE, oRAM_CE, oRAM_RD, oRAM_WR,
           oRAM_ADDR, oPCBR, oPCBR_VALID, oMISALIGN, oILLEGAL, oERR, dbgState
  );

  modport master (
    output iVALID, iIR, iPC, iREG_OUT1, iRAM_DATA, iRAM_ACK,
    input  oREADY, oRS1, oRD, oREG_IN, oREG_WE, oRAM_CE, oRAM_RD, oRAM_WR,
           oRAM_ADDR, oPCBR, oPCBR_VALID, oMISALIGN, oILLEGAL, oERR, dbgState
  );
endinterface

// File: rtl/instruction_type_i_mc_load_extract.sv
// Picks the byte/half/word lane out of a 32-bit RAM word and extends it
// to XLEN according to the load funct3.
module load_extract
  import riscv_i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     data,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  assign byteLane = data[{addr, 3'b000} +: 8];
  assign halfLane = addr[1] ? data[31:16] : data[15:0];

  // Lane select plus sign/zero extension
  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = XLEN'($signed(byteLane));
      F3_LBU:  result = XLEN'(byteLane);
      F3_LH:   result = XLEN'($signed(halfLane));
      F3_LHU:  result = XLEN'(halfLane);
      F3_LW:   result = XLEN'(data);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instruction_type_i_mc.sv
// Multi-cycle executor for RV32 ALU-immediate, load and JALR instructions.
// One instruction at a time: IDLE accepts, EXEC computes, loads go through
// LOAD (RAM request with acknowledge timeout) and WB (lane extraction).
module instruction_type_i_mc
  import riscv_i_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter logic [6:0] OPCODE_I1 = OPC_ALUI,
  parameter logic [6:0] OPCODE_I2 = OPC_LOAD,
  parameter logic [6:0] OPCODE_I3 = OPC_JALR,
  parameter int         TIMEOUT   = 16
) (
  input logic                   iCLK,
  input logic                   iRST,
  instruction_type_i_mc_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);

  state_e state;
  state_e nextState;

  logic [6:0]      opcodeQ;
  logic [2:0]      funct3Q;
  logic [4:0]      rdQ;
  logic [XLEN-1:0] pcQ;
  logic [XLEN-1:0] rs1Q;
  logic [XLEN-1:0] immQ;
  logic [31:0]     ramDataQ;
  logic [CW-1:0]   waitCnt;

  logic            accept;
  logic            timedOut;
  logic [XLEN-1:0] sum;
  logic [4:0]      shamt;
  logic [XLEN-1:0] aluRes;
  logic            aluLegal;
  logic            misaligned;
  logic [XLEN-1:0] loadRes;

  assign accept       = bus.iVALID && (state == IDLE);
  assign sum          = rs1Q + immQ;
  assign shamt        = immQ[4:0];
  assign timedOut     = (waitCnt == WAIT_MAX);
  assign bus.oRS1     = bus.iIR[19:15];
  assign bus.oRAM_WR  = 1'b0;
  assign bus.dbgState = state;

  // FSM state register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= nextState;
  end

  // Latch the instruction fields and operands on accept
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      opcodeQ <= '0;
      funct3Q <= '0;
      rdQ     <= '0;
      pcQ     <= '0;
      rs1Q    <= '0;
      immQ    <= '0;
    end else if (accept) begin
      opcodeQ <= bus.iIR[6:0];
      funct3Q <= bus.iIR[14:12];
      rdQ     <= bus.iIR[11:7];
      pcQ     <= bus.iPC;
      rs1Q    <= bus.iREG_OUT1;
      immQ    <= XLEN'($signed(bus.iIR[31:20]));
    end
  end

  // Capture RAM data on acknowledge and count unacknowledged LOAD cycles;
  // the timeout cycle itself ignores any acknowledge
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ramDataQ <= '0;
      waitCnt  <= '0;
    end else if ((state == LOAD) && !timedOut) begin
      if (bus.iRAM_ACK) begin
        ramDataQ <= bus.iRAM_DATA;
        waitCnt  <= '0;
      end else begin
        waitCnt <= waitCnt + CW'(1);
      end
    end else begin
      waitCnt <= '0;
    end
  end

  // ALU-immediate result; compares use the full sign-extended immediate
  always_comb begin
    aluRes   = '0;
    aluLegal = 1'b1;
    case (funct3Q)
      F3_ADDI:  aluRes = sum;
      F3_SLLI:  aluRes = rs1Q << shamt;
      F3_SLTI:  aluRes = XLEN'($signed(rs1Q) < $signed(immQ));
      F3_SLTIU: aluRes = XLEN'(rs1Q < immQ);
      F3_XORI:  aluRes = rs1Q ^ immQ;
      F3_ORI:   aluRes = rs1Q | immQ;
      F3_ANDI:  aluRes = rs1Q & immQ;
      F3_SRXI: begin
        if (immQ[11:5] == F7_SRLI)      aluRes = rs1Q >> shamt;
        else if (immQ[11:5] == F7_SRAI) aluRes = $unsigned($signed(rs1Q) >>> shamt);
        else                            aluLegal = 1'b0;
      end
      default:  aluLegal = 1'b0;
    endcase
  end

  // Halfwords need even addresses, words need 4-byte alignment
  always_comb begin
    misaligned = 1'b0;
    if ((funct3Q == F3_LH) || (funct3Q == F3_LHU)) misaligned = sum[0];
    else if (funct3Q == F3_LW)                     misaligned = (sum[1:0] != 2'b00);
  end

  load_extract #(.XLEN(XLEN)) u_extract (
    .data  (ramDataQ),
    .addr  (sum[1:0]),
    .funct3(funct3Q),
    .result(loadRes)
  );

  // Next-state and output decode; every strobe lasts exactly one state cycle
  always_comb begin
    nextState       = state;
    bus.oREADY      = 1'b0;
    bus.oRD         = '0;
    bus.oREG_IN     = '0;
    bus.oREG_WE     = 1'b0;
    bus.oRAM_CE     = 1'b0;
    bus.oRAM_RD     = 1'b0;
    bus.oRAM_ADDR   = '0;
    bus.oPCBR       = '0;
    bus.oPCBR_VALID = 1'b0;
    bus.oMISALIGN   = 1'b0;
    bus.oILLEGAL    = 1'b0;
    bus.oERR        = 1'b0;
    case (state)
      IDLE: begin
        bus.oREADY = 1'b1;
        if (accept) nextState = EXEC;
      end
      EXEC: begin
        nextState = IDLE;
        if (opcodeQ == OPCODE_I1) begin
          if (aluLegal) begin
            bus.oRD     = rdQ;
            bus.oREG_IN = aluRes;
            bus.oREG_WE = (rdQ != 5'd0);
          end else begin
            bus.oILLEGAL = 1'b1;
          end
        end else if (opcodeQ == OPCODE_I3) begin
          if (funct3Q == F3_JALR) begin
            bus.oPCBR       = {sum[XLEN-1:1], 1'b0};
            bus.oPCBR_VALID = 1'b1;
            bus.oRD         = rdQ;
            bus.oREG_IN     = pcQ + XLEN'(4);
            bus.oREG_WE     = (rdQ != 5'd0);
          end else begin
            bus.oILLEGAL = 1'b1;
          end
        end else if (opcodeQ == OPCODE_I2) begin
          if (!isLoadF3(funct3Q)) bus.oILLEGAL = 1'b1;
          else if (misaligned)    bus.oMISALIGN = 1'b1;
          else                    nextState = LOAD;
        end else begin
          bus.oILLEGAL = 1'b1;
        end
      end
      LOAD: begin
        if (timedOut) begin
          bus.oERR  = 1'b1;
          nextState = IDLE;
        end else begin
          bus.oRAM_CE   = 1'b1;
          bus.oRAM_RD   = 1'b1;
          bus.oRAM_ADDR = {sum[XLEN-1:2], 2'b00};
          if (bus.iRAM_ACK) nextState = WB;
        end
      end
      WB: begin
        bus.oRD     = rdQ;
        bus.oREG_IN = loadRes;
        bus.oREG_WE = (rdQ != 5'd0);
        nextState   = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_type_i_mc.sv
// Directed bench for instruction_type_i_mc: write-backs and branch targets
// are predicted into queues when an instruction is issued and checked when
// the DUT strobes them.
module tb_instruction_type_i_mc;
  import riscv_i_pkg::*;

  // ---------------- clock / reset ----------------
  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  instruction_type_i_mc_if #(.XLEN(32)) bus ();

  instruction_type_i_mc #(.XLEN(32), .TIMEOUT(16)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [36:0] exp_q[$];   // {rd, data}
  logic [31:0] pcbr_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cycNo = 0, acceptCyc = 0, lastWeCyc = 0;
  int weCnt = 0, misCnt = 0, illCnt = 0, errCnt = 0, ceCnt = 0, ceRun = 0;
  int ackWait = -1;
  logic [31:0] ramWord = 32'h0;
  logic [31:0] expAddr = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [11:0] imm);
    logic [31:0] s;
    s = {{20{imm[11]}}, imm};
    case (f3)
      3'd0:    return a + s;
      3'd4:    return a ^ s;
      3'd6:    return a | s;
      default: return a & s;
    endcase
  endfunction

  // ---------------- driver / monitor tasks ----------------
  // One clock: sample at the falling edge, then drive the RAM model
  task automatic cycle();
    logic [36:0] w;
    logic [31:0] p;
    @(negedge iCLK);
    cycNo++;
    if (bus.oREG_WE) begin
      weCnt++;
      lastWeCyc = cycNo;
      if (exp_q.size() == 0) chk("spurious_we", bus.oREG_WE, 0);
      else begin
        w = exp_q.pop_front();
        chk("writeback", {bus.oRD, bus.oREG_IN}, w);
      end
    end
    if (bus.oPCBR_VALID) begin
      if (pcbr_q.size() == 0) chk("spurious_pcbr", bus.oPCBR_VALID, 0);
      else begin
        p = pcbr_q.pop_front();
        chk("pcbr", bus.oPCBR, p);
      end
    end
    if (bus.oMISALIGN) misCnt++;
    if (bus.oILLEGAL)  illCnt++;
    if (bus.oERR)      errCnt++;
    if (bus.oRAM_CE) begin
      ceCnt++;
      ceRun++;
      chk("ram_addr", bus.oRAM_ADDR, expAddr);
      chk("ram_rd", bus.oRAM_RD, 1);
      bus.iRAM_ACK  = (ackWait >= 0) && (ceRun == ackWait + 1);
      bus.iRAM_DATA = ramWord;
    end else begin
      ceRun = 0;
      bus.iRAM_ACK = 1'b0;
    end
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] rs1);
    chk("ready_before_accept", bus.oREADY, 1);
    bus.iVALID    = 1'b1;
    bus.iIR       = ir;
    bus.iPC       = pc;
    bus.iREG_OUT1 = rs1;
    #1;
    chk("rs1_field", bus.oRS1, ir[19:15]);
    acceptCyc = cycNo;
    cycle();
    bus.iVALID    = 1'b0;
    bus.iREG_OUT1 = $urandom();
    bus.iIR       = $urandom();
  endtask

  task automatic run_to_idle();
    int n;
    n = 0;
    while (!bus.oREADY && n < 60) begin
      cycle();
      n++;
    end
    chk("idle_within_budget", bus.oREADY, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int weB, misB, ceB, errB, illB;
    logic [2:0] f3;
    logic [11:0] imm;
    logic [31:0] a;
    logic [4:0] rd;
    logic [2:0] f3set[4];
    f3set[0] = 3'd0; f3set[1] = 3'd4; f3set[2] = 3'd6; f3set[3] = 3'd7;

    iRST = 1'b1;
    bus.iVALID = 1'b0; bus.iIR = '0; bus.iPC = '0; bus.iREG_OUT1 = '0;
    bus.iRAM_DATA = '0; bus.iRAM_ACK = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("rst_ready", bus.oREADY, 1);
    chk("rst_we", bus.oREG_WE, 0);
    chk("rst_ce", bus.oRAM_CE, 0);
    chk("rst_pcbr_valid", bus.oPCBR_VALID, 0);
    chk("rst_strobes", {bus.oERR, bus.oILLEGAL, bus.oMISALIGN, bus.oRAM_WR}, 0);
    chk("rst_reg_in", bus.oREG_IN, 0);
    chk("rst_state", bus.dbgState, IDLE);
    iRST = 1'b0;
    cycle();

    // ADDI with negative immediate, 1-cycle latency
    exp_q.push_back({5'd1, 32'h0000_0004});
    issue(itype(12'hFFF, 5'd3, F3_ADDI, 5'd1, OPC_ALUI), 32'h0, 32'h5);
    chk("addi_latency", lastWeCyc, acceptCyc + 1);
    run_to_idle();

    // Shifts and compares
    exp_q.push_back({5'd2, 32'hF800_0000});
    issue(itype(12'h404, 5'd4, F3_SRXI, 5'd2, OPC_ALUI), 32'h0, 32'h8000_0000);
    run_to_idle();
    exp_q.push_back({5'd3, 32'h0800_0000});
    issue(itype(12'h004, 5'd4, F3_SRXI, 5'd3, OPC_ALUI), 32'h0, 32'h8000_0000);
    run_to_idle();
    exp_q.push_back({5'd4, 32'h1});
    issue(itype(12'h001, 5'd4, F3_SLTI, 5'd4, OPC_ALUI), 32'h0, 32'hFFFF_FFFE);
    run_to_idle();
    exp_q.push_back({5'd5, 32'h0});
    issue(itype(12'h001, 5'd4, F3_SLTIU, 5'd5, OPC_ALUI), 32'h0, 32'hFFFF_FFFE);
    run_to_idle();
    exp_q.push_back({5'd6, 32'h8000_0000});
    issue(itype(12'h01F, 5'd4, F3_SLLI, 5'd6, OPC_ALUI), 32'h0, 32'h1);
    run_to_idle();

    // Random logical/add immediates against a small model
    for (int i = 0; i < 6; i++) begin
      f3  = f3set[$urandom_range(0, 3)];
      imm = 12'($urandom_range(0, 4095));
      a   = $urandom();
      rd  = 5'($urandom_range(1, 31));
      exp_q.push_back({rd, alu_model(f3, a, imm)});
      issue(itype(imm, 5'd7, f3, rd, OPC_ALUI), 32'h0, a);
      run_to_idle();
    end

    // Illegal: bad shift selector, unknown opcode, reserved load funct3
    weB = weCnt; illB = illCnt;
    issue(itype(12'h204, 5'd1, F3_SRXI, 5'd9, OPC_ALUI), 32'h0, 32'h1); run_to_idle();
    issue(itype(12'h000, 5'd1, 3'd0, 5'd9, 7'h33), 32'h0, 32'h1);      run_to_idle();
    issue(itype(12'h000, 5'd1, 3'd3, 5'd9, OPC_LOAD), 32'h0, 32'h100); run_to_idle();
    chk("illegal_count", illCnt - illB, 3);
    chk("illegal_no_we", weCnt - weB, 0);

    // Loads from word 0x80FF0000 at 0x100, ack after 3 wait cycles
    ramWord = 32'h80FF_0000; expAddr = 32'h100; ackWait = 3;
    exp_q.push_back({5'd7, 32'hFFFF_FF80});
    issue(itype(12'h003, 5'd2, F3_LB, 5'd7, OPC_LOAD), 32'h0, 32'h100);
    run_to_idle();
    chk("lb_latency", lastWeCyc, acceptCyc + 6);
    exp_q.push_back({5'd8, 32'h0000_0080});
    issue(itype(12'hFFF, 5'd2, F3_LBU, 5'd8, OPC_LOAD), 32'h0, 32'h104);
    run_to_idle();
    exp_q.push_back({5'd9, 32'hFFFF_80FF});
    issue(itype(12'h000, 5'd2, F3_LH, 5'd9, OPC_LOAD), 32'h0, 32'h102);
    run_to_idle();
    exp_q.push_back({5'd11, 32'h0000_80FF});
    issue(itype(12'h002, 5'd2, F3_LHU, 5'd11, OPC_LOAD), 32'h0, 32'h100);
    run_to_idle();
    ackWait = 0;
    exp_q.push_back({5'd10, 32'h80FF_0000});
    issue(itype(12'h000, 5'd2, F3_LW, 5'd10, OPC_LOAD), 32'h0, 32'h100);
    run_to_idle();
    chk("lw_latency", lastWeCyc, acceptCyc + 3);

    // Misaligned loads never touch RAM
    weB = weCnt; misB = misCnt; ceB = ceCnt;
    issue(itype(12'h002, 5'd2, F3_LW, 5'd10, OPC_LOAD), 32'h0, 32'h100); run_to_idle();
    issue(itype(12'h001, 5'd2, F3_LH, 5'd10, OPC_LOAD), 32'h0, 32'h100); run_to_idle();
    chk("misalign_count", misCnt - misB, 2);
    chk("misalign_no_ce", ceCnt - ceB, 0);
    chk("misalign_no_we", weCnt - weB, 0);

    // Acknowledge timeout
    ackWait = -1; expAddr = 32'h200;
    weB = weCnt; ceB = ceCnt; errB = errCnt;
    issue(itype(12'h000, 5'd2, F3_LW, 5'd12, OPC_LOAD), 32'h0, 32'h200);
    run_to_idle();
    chk("timeout_wait_cycles", ceCnt - ceB, 16);
    chk("timeout_err", errCnt - errB, 1);
    chk("timeout_no_we", weCnt - weB, 0);

    // JALR with and without a destination
    exp_q.push_back({5'd1, 32'h0000_0104});
    pcbr_q.push_back(32'h0000_2004);
    issue(itype(12'h004, 5'd5, F3_JALR, 5'd1, OPC_JALR), 32'h100, 32'h2001);
    run_to_idle();
    weB = weCnt;
    pcbr_q.push_back(32'h0000_2004);
    issue(itype(12'h004, 5'd5, F3_JALR, 5'd0, OPC_JALR), 32'h100, 32'h2001);
    run_to_idle();
    chk("jalr_rd0_no_we", weCnt - weB, 0);
    chk("jalr_rd0_pcbr", pcbr_q.size(), 0);

    // Reset in the middle of a load, late ack must be ignored
    expAddr = 32'h100; ackWait = -1;
    issue(itype(12'h000, 5'd2, F3_LB, 5'd12, OPC_LOAD), 32'h0, 32'h100);
    cycle();
    chk("in_load_before_reset", bus.oRAM_CE, 1);
    weB = weCnt; errB = errCnt; misB = misCnt; illB = illCnt; ceB = ceCnt;
    iRST = 1'b1;
    cycle();
    iRST = 1'b0;
    bus.iRAM_ACK = 1'b1;
    bus.iRAM_DATA = ramWord;
    cycle();
    cycle();
    cycle();
    chk("rst_abort_ready", bus.oREADY, 1);
    chk("rst_abort_no_we", weCnt - weB, 0);
    chk("rst_abort_no_ce", ceCnt - ceB, 0);
    chk("rst_abort_no_strobes", (errCnt - errB) + (misCnt - misB) + (illCnt - illB), 0);
    exp_q.push_back({5'd13, 32'h0000_0011});
    issue(itype(12'h007, 5'd6, F3_ADDI, 5'd13, OPC_ALUI), 32'h0, 32'hA);
    run_to_idle();

    chk("wb_queue_drained", exp_q.size(), 0);
    chk("pcbr_queue_drained", pcbr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
